// File: rtl/ssp_rx_fifo_param.sv
// ssp_rx_fifo_param
//   Parametrised receive FIFO for the synchronous serial port. The receive
//   shifter writes words in; the register read path pops them out. It also
//   produces the level, overrun and receive-timeout interrupts.
//
// Ports
//   pclk        clock, all state on rising edge
//   clear       asynchronous active-high reset
//   psel        register-path select
//   pwrite      0 = read request while psel=1
//   w_en        write strobe from receive shifter (one word per cycle)
//   rxdata      received word
//   ovr_clr     single-cycle clear of the sticky overrun flag
//   prdata      registered read data (valid the cycle after the read edge)
//   rx_level    occupancy 0..DEPTH
//   rx_empty    rx_level == 0
//   rx_full     rx_level == DEPTH
//   ssprxintr   level interrupt (rx_level >= RX_THRESH)
//   ssprorintr  sticky overrun interrupt
//   ssprtintr   receive-timeout interrupt
module ssp_rx_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int RX_THRESH  = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic                    pclk,
    input  logic                    clear,
    input  logic                    psel,
    input  logic                    pwrite,
    input  logic                    w_en,
    input  logic [DATA_WIDTH-1:0]   rxdata,
    input  logic                    ovr_clr,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic [$clog2(DEPTH):0]  rx_level,
    output logic                    rx_empty,
    output logic                    rx_full,
    output logic                    ssprxintr,
    output logic                    ssprorintr,
    output logic                    ssprtintr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  ovr_q, ovr_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    logic rd, wr, ovr;

    assign rx_empty = (level_q == '0);
    assign rx_full  = (level_q == LW'(DEPTH));

    // A read frees a slot in the same cycle, so a write to a full FIFO is
    // still accepted when it coincides with a read.
    assign rd  = psel && !pwrite && !rx_empty;
    assign wr  = w_en && (!rx_full || rd);
    assign ovr = w_en && rx_full && !rd;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        level_d  = level_q;
        prdata_d = prdata_q;
        ovr_d    = ovr_q;
        tmo_d    = tmo_q;

        if (wr) wptr_d = wptr_q + AW'(1);
        if (rd) begin
            rptr_d   = rptr_q + AW'(1);
            prdata_d = mem_q[rptr_q];
        end

        case ({wr, rd})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Set has priority over clear.
        if (ovr)          ovr_d = 1'b1;
        else if (ovr_clr) ovr_d = 1'b0;

        // Idle time is only counted while data sits unread; saturates.
        if (wr || rd || rx_empty)        tmo_d = '0;
        else if (tmo_q != TW'(TIMEOUT))  tmo_d = tmo_q + TW'(1);
    end

    always_ff @(posedge pclk or posedge clear) begin
        if (clear) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            prdata_q <= '0;
            ovr_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            prdata_q <= prdata_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
        end
    end

    // Storage is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge pclk) begin
        if (wr) mem_q[wptr_q] <= rxdata;
    end

    assign prdata     = prdata_q;
    assign rx_level   = level_q;
    assign ssprxintr  = (level_q >= LW'(RX_THRESH));
    assign ssprorintr = ovr_q;
    assign ssprtintr  = (tmo_q == TW'(TIMEOUT));

endmodule
